instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch_fifo.sv | 58 +++++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (issue, await response, discard stale response)
//   fetch_entry_t : one instruction buffer entry {instruction word, its pc}
package instr_fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,  // may issue a fetch request
        F_WAIT = 2'd1,  // request accepted, awaiting rvalid
        F_DROP = 2'd2   // awaiting one stale rvalid that must be discarded
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: instruction buffer between fetch and decode.
//   clk, rst_n : clock, async active-low reset (storage cleared so the head reads 0)
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the buffer; wins over a same-cycle push/pop
//   count      : number of valid entries
//   full       : count == DEPTH
//   head       : registered entry at the head (meaningful when count != 0)
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output logic         full,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with a small decode buffer and
// branch redirect. At most one memory request is outstanding; a response that
// belongs to a pre-redirect request is discarded.
//   clk, rst_n                     : clock, async active-low reset
//   imem_req/imem_addr/imem_ready  : request channel to instruction memory
//   imem_rvalid/imem_rdata         : response channel (one pulse per accepted request)
//   instr_valid/instr/instr_pc     : buffer head toward decode
//   instr_ready                    : decode consumes the head
//   branch_take/branch_target      : one-cycle redirect from execute
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    input  logic               instr_ready,
    input  logic               branch_take,
    input  logic [31:0]        branch_target
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state, state_nxt;
    logic [31:0]   pc, req_pc;
    logic [CW-1:0] count;
    logic          full, accept, push, pop;
    fetch_entry_t  head, push_data;

    // rst_n gates the request so nothing is issued while reset is held, yet
    // the first request appears in the very cycle reset is released.
    assign imem_req  = rst_n && (state == F_REQ) && !full;
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;

    // A redirect in the response cycle makes that response stale.
    assign push      = (state == F_WAIT) && imem_rvalid && !branch_take;
    assign pop       = instr_valid && instr_ready;
    assign push_data = '{instr: imem_rdata, pc: req_pc};

    always_comb begin
        state_nxt = state;
        unique case (state)
            F_REQ: begin
                if (branch_take)  state_nxt = accept ? F_DROP : F_REQ;
                else if (accept)  state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (imem_rvalid)      state_nxt = F_REQ;
                else if (branch_take) state_nxt = F_DROP;
            end
            F_DROP: begin
                if (imem_rvalid) state_nxt = F_REQ;
            end
            default: state_nxt = F_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= F_REQ;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (branch_take)  pc <= align_word(branch_target);
            else if (accept)  pc <= pc + PC_STEP;
            if (accept) req_pc <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (branch_take),
        .count     (count),
        .full      (full),
        .head      (head)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a response-delay memory
// model and a scoreboard of expected {instr, pc} entries.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk, rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready, branch_take;
    logic [31:0] instr, instr_pc, branch_target;

    // second instance for the wrap-around reset address
    logic        req2, ready2, rv2, iv2, iready2, bt2;
    logic [31:0] addr2, rdata2, i2, ipc2, btgt2;
    logic [31:0] addrs2[$];

    int checks = 0;
    int errors = 0;

    fetch_entry_t sb_q[$];
    logic [31:0]  pc_log[$];
    logic         inflight, stale, outstanding;
    logic [31:0]  out_addr;
    int           wait_cnt, rsp_delay;

    instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .branch_take(branch_take), .branch_target(branch_target)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rvalid(rv2), .imem_rdata(rdata2),
        .instr_valid(iv2), .instr(i2), .instr_pc(ipc2),
        .instr_ready(iready2),
        .branch_take(bt2), .branch_target(btgt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut2 memory: always ready, answers one cycle after each accept
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rv2 <= 1'b0;
        else begin
            rv2 <= req2 && ready2;
            if (req2 && ready2) addrs2.push_back(addr2);
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score the current cycle, then advance the memory model.
    task automatic tick();
        logic         acc, rv, br;
        logic [31:0]  acc_addr;
        fetch_entry_t e;
        #1;
        acc      = imem_req && imem_ready;
        rv       = imem_rvalid;
        br       = branch_take;
        acc_addr = imem_addr;
        if (instr_valid && instr_ready && !br) begin
            if (sb_q.size() == 0) chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
            else begin
                e = sb_q.pop_front();
                chk("sb_instr", instr, e.instr);
                chk("sb_pc", instr_pc, e.pc);
                pc_log.push_back(instr_pc);
            end
        end
        if (acc) chk("one_outstanding", {31'b0, inflight}, 32'd0);
        if (rv) begin
            if (!br && !stale) sb_q.push_back('{instr: imem_rdata, pc: out_addr});
            stale    = 1'b0;
            inflight = 1'b0;
        end
        if (br) begin
            sb_q.delete();
            if (acc || inflight) stale = 1'b1;
        end
        if (acc) inflight = 1'b1;
        @(posedge clk); #1;
        branch_take = 1'b0;
        imem_rvalid = 1'b0;
        if (acc) begin
            out_addr    = acc_addr;
            wait_cnt    = rsp_delay;
            outstanding = 1'b1;
        end
        if (outstanding) begin
            wait_cnt--;
            if (wait_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(out_addr);
                outstanding = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        inflight = 0; stale = 0; outstanding = 0;
        imem_rvalid = 0; branch_take = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_pops(input int n, input int bound, input string tag);
        int k = 0;
        pc_log.delete();
        while (pc_log.size() < n && k < bound) begin tick(); k++; end
        chk(tag, 32'(pc_log.size()), 32'(n));
    endtask

    task automatic wait_req(input int bound, input string tag);
        int k = 0;
        while (!imem_req && k < bound) begin tick(); k++; end
        chk(tag, {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        imem_ready = 1; instr_ready = 1; branch_take = 0; branch_target = 0;
        imem_rvalid = 0; imem_rdata = 0; rsp_delay = 1; rst_n = 0;
        inflight = 0; stale = 0; outstanding = 0; out_addr = 0; wait_cnt = 0;
        ready2 = 1; rdata2 = 0; iready2 = 1; bt2 = 0; btgt2 = 0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        rst_n = 1; #1;
        chk("first_req", {31'b0, imem_req}, 1);
        chk("first_addr", imem_addr, 32'h0);

        // sequential stream with one-cycle response latency
        tick();
        chk("lat_not_yet", {31'b0, instr_valid}, 0);
        tick();
        chk("lat_valid", {31'b0, instr_valid}, 1);
        chk("lat_pc", instr_pc, 32'h0);
        run_pops(4, 40, "seq_pops");
        for (int i = 0; i < 4 && i < pc_log.size(); i++)
            chk("seq_pc", pc_log[i], 32'(4 * i));

        // decode stall: buffer fills to two entries, requests stop
        do_reset();
        instr_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 5) chk("stall_req", {31'b0, imem_req}, 0);
        end
        chk("stall_valid", {31'b0, instr_valid}, 1);
        chk("stall_entries", 32'(sb_q.size()), 2);
        instr_ready = 1;
        run_pops(2, 10, "stall_pops");
        if (pc_log.size() >= 2) begin
            chk("stall_pc0", pc_log[0], 32'h0);
            chk("stall_pc1", pc_log[1], 32'h4);
        end

        // redirect while awaiting a response, buffer non-empty
        do_reset();
        instr_ready = 0; rsp_delay = 1;
        tick();
        rsp_delay = 3;
        tick();
        tick();
        chk("br_wait_pre_valid", {31'b0, instr_valid}, 1);
        branch_take = 1; branch_target = 32'h0000_0103; instr_ready = 1;
        tick();
        chk("br_wait_flushed", {31'b0, instr_valid}, 0);
        chk("br_wait_drop_req", {31'b0, imem_req}, 0);
        wait_req(10, "br_wait_req");
        chk("br_wait_addr", imem_addr, 32'h0000_0100);
        chk("br_wait_stale_gone", {31'b0, instr_valid}, 0);
        rsp_delay = 1;
        run_pops(2, 20, "br_wait_pops");
        if (pc_log.size() >= 2) begin
            chk("br_wait_pc0", pc_log[0], 32'h100);
            chk("br_wait_pc1", pc_log[1], 32'h104);
        end

        // redirect in the same cycle as the response
        do_reset();
        instr_ready = 1; rsp_delay = 2;
        tick();
        chk("br_rv_wait_noreq", {31'b0, imem_req}, 0);
        tick();
        branch_take = 1; branch_target = 32'h40;
        tick();
        chk("br_rv_req", {31'b0, imem_req}, 1);
        chk("br_rv_addr", imem_addr, 32'h40);
        chk("br_rv_nopush", {31'b0, instr_valid}, 0);
        rsp_delay = 1;
        run_pops(1, 20, "br_rv_pops");
        if (pc_log.size() >= 1) chk("br_rv_pc0", pc_log[0], 32'h40);

        // redirect in the cycle a request is accepted
        do_reset();
        instr_ready = 1; rsp_delay = 1;
        branch_take = 1; branch_target = 32'h82;
        tick();
        chk("br_acc_drop_req", {31'b0, imem_req}, 0);
        wait_req(10, "br_acc_req");
        chk("br_acc_addr", imem_addr, 32'h80);
        run_pops(1, 20, "br_acc_pops");
        if (pc_log.size() >= 1) chk("br_acc_pc0", pc_log[0], 32'h80);

        // reset while a request is outstanding with one entry buffered
        do_reset();
        instr_ready = 0; rsp_delay = 1;
        tick();
        rsp_delay = 3;
        tick();
        tick();
        chk("rst_mid_pre_valid", {31'b0, instr_valid}, 1);
        #2;
        rst_n = 0; #1;
        chk("rst_mid_valid", {31'b0, instr_valid}, 0);
        chk("rst_mid_req", {31'b0, imem_req}, 0);
        do_reset();
        chk("rst_mid_addr", imem_addr, 32'h0);
        chk("rst_mid_req_after", {31'b0, imem_req}, 1);
        rsp_delay = 1; instr_ready = 1;
        run_pops(1, 20, "rst_mid_pops");
        if (pc_log.size() >= 1) chk("rst_mid_pc0", pc_log[0], 32'h0);

        // wrap-around from the top of the address space (second instance)
        if (addrs2.size() >= 2) begin
            chk("wrap_addr0", addrs2[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", addrs2[1], 32'h0000_0000);
        end else chk("wrap_count", 32'(addrs2.size()), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
